// File: rtl/program_image_loader.sv
// program_image_loader
//
// Boot-time loader between the image byte stream and the DRAM model. Bytes of the code
// segment, then the data segment, are packed little-endian into 64-bit words and written
// at CODE_BASE / DATA_BASE. When the data segment's last word is written, core_start is
// raised to release the fetch stage.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   load_start              one-cycle pulse, honoured in IDLE only
//   in_valid/in_ready       byte stream handshake
//   in_data, in_last        stream byte, last byte of the current segment
//   mem_wr_valid/ready      word write handshake
//   mem_wr_addr             8-aligned byte address of the word
//   mem_wr_data             packed word, unfilled bytes zero
//   mem_wr_byte_en          one enable bit per byte lane
//   core_start              level, high once the load has completed
//   busy                    high while loading or writing
//   error                   sticky segment-overflow flag
//   code_bytes, data_bytes  bytes accepted per segment
module program_image_loader #(
  parameter logic [20:0] CODE_BASE     = 21'h000000,
  parameter logic [20:0] DATA_BASE     = 21'h100000,
  parameter int unsigned SEGMENT_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [20:0] mem_wr_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_wr_byte_en,
  output logic        core_start,
  output logic        busy,
  output logic        error,
  output logic [20:0] code_bytes,
  output logic [20:0] data_bytes
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadCode,
    StLoadData,
    StWrite,
    StDone,
    StError
  } state_e;

  localparam logic [20:0] SegLimit = 21'(SEGMENT_BYTES);

  state_e      state_q, state_d;
  logic [63:0] buf_q, buf_d;
  logic [7:0]  be_q, be_d;
  logic [2:0]  idx_q, idx_d;
  logic [17:0] word_idx_q, word_idx_d;
  logic [20:0] code_cnt_q, code_cnt_d;
  logic [20:0] data_cnt_q, data_cnt_d;
  logic        seg_q, seg_d;    // 0: code segment, 1: data segment
  logic        last_q, last_d;  // in_last was seen on the word being written
  logic        error_q, error_d;

  logic [20:0] seg_cnt;
  logic [20:0] seg_base;

  assign seg_cnt  = seg_q ? data_cnt_q : code_cnt_q;
  assign seg_base = seg_q ? DATA_BASE : CODE_BASE;

  assign in_ready       = (state_q == StLoadCode) || (state_q == StLoadData);
  assign mem_wr_valid   = (state_q == StWrite);
  // Address/data/enables come straight from registers that only change on the handshake,
  // so the request holds stable under backpressure.
  assign mem_wr_addr    = mem_wr_valid ? (seg_base + {word_idx_q, 3'b000}) : '0;
  assign mem_wr_data    = mem_wr_valid ? buf_q : '0;
  assign mem_wr_byte_en = mem_wr_valid ? be_q : '0;
  assign core_start     = (state_q == StDone);
  assign busy           = in_ready || mem_wr_valid;
  assign error          = error_q;
  assign code_bytes     = code_cnt_q;
  assign data_bytes     = data_cnt_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    be_d       = be_q;
    idx_d      = idx_q;
    word_idx_d = word_idx_q;
    code_cnt_d = code_cnt_q;
    data_cnt_d = data_cnt_q;
    seg_d      = seg_q;
    last_d     = last_q;
    error_d    = error_q;

    case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d    = StLoadCode;
          buf_d      = '0;
          be_d       = '0;
          idx_d      = '0;
          word_idx_d = '0;
          code_cnt_d = '0;
          data_cnt_d = '0;
          seg_d      = 1'b0;
          last_d     = 1'b0;
        end
      end

      StLoadCode, StLoadData: begin
        if (in_valid) begin
          if (seg_cnt == SegLimit) begin
            // Overflowing byte is dropped; the load is abandoned.
            error_d = 1'b1;
            state_d = StError;
          end else begin
            buf_d[{idx_q, 3'b000} +: 8] = in_data;
            be_d[idx_q]                 = 1'b1;
            idx_d                       = idx_q + 3'd1;
            last_d                      = in_last;
            if (seg_q) begin
              data_cnt_d = data_cnt_q + 21'd1;
            end else begin
              code_cnt_d = code_cnt_q + 21'd1;
            end
            if (idx_q == 3'd7 || in_last) begin
              state_d = StWrite;
            end
          end
        end
      end

      StWrite: begin
        if (mem_wr_ready) begin
          word_idx_d = word_idx_q + 18'd1;
          buf_d      = '0;
          be_d       = '0;
          idx_d      = '0;
          last_d     = 1'b0;
          if (!last_q) begin
            state_d = seg_q ? StLoadData : StLoadCode;
          end else if (!seg_q) begin
            state_d    = StLoadData;
            seg_d      = 1'b1;
            word_idx_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone, StError: state_d = state_q;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      be_q       <= '0;
      idx_q      <= '0;
      word_idx_q <= '0;
      code_cnt_q <= '0;
      data_cnt_q <= '0;
      seg_q      <= 1'b0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      be_q       <= be_d;
      idx_q      <= idx_d;
      word_idx_q <= word_idx_d;
      code_cnt_q <= code_cnt_d;
      data_cnt_q <= data_cnt_d;
      seg_q      <= seg_d;
      last_q     <= last_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_program_image_loader.sv
module tb_program_image_loader;

  localparam logic [20:0] CodeBase = 21'h000000;
  localparam logic [20:0] DataBase = 21'h100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [20:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_byte_en;
  logic        core_start;
  logic        busy;
  logic        error;
  logic [20:0] code_bytes;
  logic [20:0] data_bytes;

  program_image_loader #(
    .CODE_BASE    (CodeBase),
    .DATA_BASE    (DataBase),
    .SEGMENT_BYTES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_ready  (mem_wr_ready),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_byte_en(mem_wr_byte_en),
    .core_start    (core_start),
    .busy          (busy),
    .error         (error),
    .code_bytes    (code_bytes),
    .data_bytes    (data_bytes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [20:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push_wr(input logic [20:0] a, input logic [63:0] d, input logic [7:0] b);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = b;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every completed write handshake is checked against the queue.
  always @(negedge clk) begin
    if (mem_wr_valid === 1'b1 && mem_wr_ready === 1'b1) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be 0x%0h, want none",
                 mem_wr_addr, mem_wr_data, mem_wr_byte_en);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_wr_addr, e.addr);
        chk("wr_data", mem_wr_data, e.data);
        chk("wr_be", mem_wr_byte_en, e.be);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_valid"}, mem_wr_valid, 0);
    chk({tag, "_wr_addr"}, mem_wr_addr, 0);
    chk({tag, "_wr_data"}, mem_wr_data, 0);
    chk({tag, "_wr_be"}, mem_wr_byte_en, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_code_bytes"}, code_bytes, 0);
    chk({tag, "_data_bytes"}, data_bytes, 0);
  endtask

  // All stimulus tasks return at posedge+1.
  task automatic do_reset();
    reset        = 1'b1;
    load_start   = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    in_data      = 8'h00;
    mem_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    chk("start_in_ready_n", in_ready, 0);
    @(posedge clk);
    #1 load_start = 1'b0;
    @(negedge clk);
    chk("start_in_ready_n1", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready 0 for byte 0x%0h, want 1", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_count < target && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (hs_count < target) begin
      n_checks++;
      $display("FAIL hs_timeout: got %0d writes, want %0d", hs_count, target);
    end
  endtask

  task automatic basic_load(input bit gaps);
    int base;
    base = hs_count;
    push_wr(CodeBase, 64'h0706050403020100, 8'hFF);
    push_wr(CodeBase + 21'd8, 64'h0F0E0D0C0B0A0908, 8'hFF);
    push_wr(DataBase, 64'hA7A6A5A4A3A2A1A0, 8'hFF);
    start_load();
    for (int i = 0; i < 24; i++) begin
      if (i < 16) send_byte(8'(i), i == 15);
      else send_byte(8'(8'hA0 + i - 16), i == 23);
      if (gaps) begin
        // load_start while busy must be ignored.
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
      end
    end
    wait_hs(base + 3);
    @(negedge clk);
    chk("basic_core_start", core_start, 1);
    chk("basic_code_bytes", code_bytes, 16);
    chk("basic_data_bytes", data_bytes, 8);
    chk("basic_busy", busy, 0);
    chk("basic_in_ready", in_ready, 0);
  endtask

  initial begin
    int base;
    reset        = 1'b1;
    load_start   = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    in_data      = 8'h00;
    mem_wr_ready = 1'b1;
    #2;
    check_reset_outputs("por");
    do_reset();

    // Basic load, zero-wait memory.
    basic_load(1'b0);

    // Partial words with 5 cycles of backpressure on the first write.
    do_reset();
    base = hs_count;
    push_wr(CodeBase, 64'h0000000000332211, 8'h07);
    push_wr(DataBase, 64'h0000000000000044, 8'h01);
    mem_wr_ready = 1'b0;
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", mem_wr_valid, 1);
      chk("bp_addr", mem_wr_addr, CodeBase);
      chk("bp_data", mem_wr_data, 64'h0000000000332211);
      chk("bp_be", mem_wr_byte_en, 8'h07);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_no_early_write", hs_count, base);
    @(posedge clk);
    #1 mem_wr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_write_done", hs_count, base + 1);
    chk("bp_in_ready_after", in_ready, 1);
    send_byte(8'h44, 1'b1);
    wait_hs(base + 2);
    @(negedge clk);
    chk("partial_core_start", core_start, 1);
    chk("partial_code_bytes", code_bytes, 3);
    chk("partial_data_bytes", data_bytes, 1);

    // Reset mid-load: partial word must vanish, then a full load must work.
    do_reset();
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0);
    chk("midload_code_bytes", code_bytes, 5);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    basic_load(1'b0);

    // Stream gaps with spurious load_start pulses.
    do_reset();
    basic_load(1'b1);

    // Overflow with a 16-byte segment limit.
    do_reset();
    base = hs_count;
    push_wr(CodeBase, 64'h0706050403020100, 8'hFF);
    push_wr(CodeBase + 21'd8, 64'h0F0E0D0C0B0A0908, 8'hFF);
    start_load();
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    chk("ovf_error", error, 1);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_wr_valid", mem_wr_valid, 0);
    chk("ovf_core_start", core_start, 0);
    chk("ovf_code_bytes", code_bytes, 16);
    chk("ovf_writes", hs_count, base + 2);
    repeat (5) @(negedge clk);
    chk("ovf_core_start_later", core_start, 0);
    chk("ovf_in_ready_later", in_ready, 0);
    chk("ovf_error_sticky", error, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

endmodule
